btisa_seq_ctrl: RTL and testbench
=================================

BTISA_SEQ_CTRL -- requirements
Module: btisa_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum wait cycles for a memory acknowledge before error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin execution from IDLE.
REQ-005 reg_write, mem_read, mem_write, branch, jump, halt  input  1 each  decoded control signals for the current instruction; held stable while the instruction register is unchanged.
REQ-006 branch_taken  input  1  branch comparison result from the ALU.
REQ-007 imem_ack, dmem_ack  input  1 each  instruction/data memory acknowledge.
REQ-008 imem_req, dmem_req, dmem_we  output  1 each  memory request strobes; dmem_we marks a write.
REQ-009 ir_load  output  1  load instruction register.
REQ-010 rf_we  output  1  register file write enable.
REQ-011 pc_we  output  1  PC update enable.
REQ-012 pc_sel  output  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target; 11 is never driven.
REQ-013 busy, halted, err  output  1 each  status flags.
REQ-014 instr_count  output  16  count of retired instructions.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR; one transition per clock.
REQ-016 IDLE: start=1 -> FETCH; all other inputs ignored.
REQ-017 FETCH: imem_req=1 every cycle; in the cycle imem_ack=1, ir_load=1 (same cycle) and next state is DECODE.
REQ-018 DECODE: one cycle; halt=1 -> HALT, else -> EXEC; no strobes asserted.
REQ-019 EXEC: one cycle; priority mem_read|mem_write -> MEM, else reg_write -> WB, else retire (REQ-023) -> FETCH.
REQ-020 MEM: dmem_req=1 and dmem_we=mem_write every cycle; on dmem_ack: mem_read -> WB, else retire -> FETCH.
REQ-021 WB: rf_we=1 for exactly one cycle, retire, -> FETCH.
REQ-022 ir_load, rf_we and pc_we are single-cycle pulses per instruction; imem_req and dmem_req are never high in the same cycle.
REQ-023 Retire means pc_we=1 for one cycle and instr_count+1, saturating at 16'hFFFF (no wrap).
REQ-024 pc_sel is valid only while pc_we=1: jump=1 -> 10; else branch & branch_taken -> 01; else 00. pc_sel=00 whenever pc_we=0.
REQ-025 Timeout counter clears on entry to FETCH or MEM and increments each cycle without ack; when it reaches TIMEOUT_CYCLES without ack -> ERR.
REQ-026 An ack arriving in the same cycle the count reaches TIMEOUT_CYCLES is honoured; no ERR.
REQ-027 HALT: halted=1, all strobes 0; start is ignored; leave only by reset.
REQ-028 ERR: err=1 (sticky), all strobes 0; start is ignored; leave only by reset.
REQ-029 busy=1 in FETCH, DECODE, EXEC, MEM, WB; busy=0 otherwise.
REQ-030 Acks outside FETCH/MEM are ignored.

Reset
REQ-031 rst_n=0 forces IDLE immediately, regardless of the clock, including mid-FETCH or mid-MEM.
REQ-032 During reset and after release: all outputs 0 and instr_count=0; an in-flight memory request is dropped without retire.

Verification
REQ-033 ADD: start, imem_ack on the 1st FETCH cycle, reg_write=1 -> states FETCH, DECODE, EXEC, WB; rf_we and pc_we in the WB cycle, pc_sel=00, instr_count=1.
REQ-034 LD with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, dmem_we=0, then WB; BEQ taken with no reg_write -> pc_we in EXEC, pc_sel=01.
REQ-035 JAL (jump=1, reg_write=1) -> pc_sel=10 with pc_we in WB; ST -> dmem_we=1, retire on ack, rf_we never asserted.
REQ-036 imem_ack withheld: ERR entered after 15 FETCH cycles, err=1 and held; ack on the 15th cycle -> DECODE, err=0.
REQ-037 HALT decoded -> halted=1, busy=0; start pulses ignored; rst_n=0 pulse -> IDLE with all outputs 0.
REQ-038 Preload instr_count to 16'hFFFE via 2 retirements with a forced count: further retirements -> value stays 16'hFFFF.

Source files
------------

// File: rtl/btisa_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and its datapath/memories.
// The sequencer takes the master side: it drives the strobes and status flags
// and consumes the decoded control lines and memory acknowledges.
`timescale 1ns/1ps
interface btisa_seq_ctrl_if;
    logic        start;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        halt;
    logic        branch_taken;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        ir_load;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] instr_count;

    modport master (
        input  start, reg_write, mem_read, mem_write, branch, jump, halt,
               branch_taken, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel,
               busy, halted, err, instr_count
    );

    modport slave (
        output start, reg_write, mem_read, mem_write, branch, jump, halt,
               branch_taken, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, pc_sel,
               busy, halted, err, instr_count
    );
endinterface

// File: rtl/btisa_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// acknowledge timeouts, terminal HALT/ERR states and a saturating retire
// counter. Strobes are decoded from the current state (ir_load and the MEM
// retire additionally qualify on the acknowledge seen in that cycle).
`timescale 1ns/1ps
module btisa_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    btisa_seq_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic [15:0]   instr_count_reg;
    logic          retire;
    logic          waiting;
    logic          tmo_hit;

    // The count is checked one cycle early so the cycle it would reach the
    // limit is the last one in which an ack can still be honoured.
    assign tmo_hit = (tmo_reg == TW'(TIMEOUT_CYCLES - 1));

    // Waiting on an ack in FETCH or MEM; any other state holds the counter
    // at zero, so every entry into FETCH/MEM starts a fresh count.
    assign waiting = ((state_reg == S_FETCH) && !bus.imem_ack) ||
                     ((state_reg == S_MEM)   && !bus.dmem_ack);
    assign tmo_next = waiting ? (tmo_reg + TW'(1)) : '0;

    // Instruction completes: EXEC with nothing further to do, a store-type
    // MEM access on ack, or the write-back cycle.
    assign retire = ((state_reg == S_EXEC) && !bus.mem_read && !bus.mem_write && !bus.reg_write) ||
                    ((state_reg == S_MEM) && bus.dmem_ack && !bus.mem_read) ||
                    (state_reg == S_WB);

    // Next-state selection, one transition per clock.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack)  state_next = S_DECODE;
                else if (tmo_hit)  state_next = S_ERR;
            end
            S_DECODE: state_next = bus.halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (bus.mem_read || bus.mem_write) state_next = S_MEM;
                else if (bus.reg_write)            state_next = S_WB;
                else                               state_next = S_FETCH;
            end
            S_MEM: begin
                if (bus.dmem_ack)  state_next = bus.mem_read ? S_WB : S_FETCH;
                else if (tmo_hit)  state_next = S_ERR;
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            S_ERR:    state_next = S_ERR;
            default:  state_next = S_IDLE;
        endcase
    end

    // State and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tmo_reg   <= tmo_next;
        end
    end

    // Retired-instruction counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_reg <= '0;
        end else if (retire && (instr_count_reg != 16'hFFFF)) begin
            instr_count_reg <= instr_count_reg + 16'd1;
        end
    end

    assign bus.imem_req    = (state_reg == S_FETCH);
    assign bus.ir_load     = (state_reg == S_FETCH) && bus.imem_ack;
    assign bus.dmem_req    = (state_reg == S_MEM);
    assign bus.dmem_we     = (state_reg == S_MEM) && bus.mem_write;
    assign bus.rf_we       = (state_reg == S_WB);
    assign bus.pc_we       = retire;
    assign bus.pc_sel      = !retire                         ? 2'b00 :
                             bus.jump                        ? 2'b10 :
                             (bus.branch && bus.branch_taken) ? 2'b01 : 2'b00;
    assign bus.busy        = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                             (state_reg == S_EXEC)  || (state_reg == S_MEM) ||
                             (state_reg == S_WB);
    assign bus.halted      = (state_reg == S_HALT);
    assign bus.err         = (state_reg == S_ERR);
    assign bus.instr_count = instr_count_reg;
endmodule

// File: tb/tb_btisa_seq_ctrl.sv
// Bench for btisa_seq_ctrl: directed and random instructions, each expanded
// by a behavioural model into its expected per-cycle output trace.
`timescale 1ns/1ps
module tb_btisa_seq_ctrl;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    btisa_seq_ctrl_if bus();

    btisa_seq_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    // Observed vector: {imem_req,dmem_req,dmem_we,ir_load,rf_we,pc_we,pc_sel,busy,halted,err}
    logic [10:0] obs;
    assign obs = {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load, bus.rf_we,
                  bus.pc_we, bus.pc_sel, bus.busy, bus.halted, bus.err};

    function automatic logic [10:0] mk(input bit imr, dmr, dwe, irl, rfw, pcw,
                                       input logic [1:0] psel, input bit bsy, hlt, er);
        return {imr, dmr, dwe, irl, rfw, pcw, psel, bsy, hlt, er};
    endfunction

    localparam logic [10:0] V_IDLE = 11'd0;

    function automatic logic [10:0] v_halt();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
    endfunction

    function automatic logic [10:0] v_err();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    endfunction

    task automatic count_retire();
        if (exp_count < 65535) exp_count++;
    endtask

    // One clock: compare outputs at the falling edge, then advance.
    task automatic step(input logic [10:0] e, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        checks++;
        assert (bus.instr_count === 16'(exp_count)) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.instr_count, 16'(exp_count));
        end
    endtask

    // Run one instruction starting in FETCH: idel cycles before imem_ack,
    // ddel cycles before dmem_ack. Returns with the DUT in FETCH, HALT or ERR.
    task automatic run_instr(input string tag, input bit rw, mr, mw, br, bt, jmp, hlt,
                             input int idel, input int ddel);
        logic [1:0] psel;
        bit ret;
        bit last;
        bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw;
        bus.branch = br; bus.branch_taken = bt; bus.jump = jmp; bus.halt = hlt;
        psel = jmp ? 2'b10 : ((br && bt) ? 2'b01 : 2'b00);
        for (int k = 0; k <= TMO; k++) begin
            if (k == TMO) begin
                bus.imem_ack = 1'b0;
                step(v_err(), {tag, "_ferr"});
                check_count({tag, "_cnt"});
                $display("instr %s: fetch timeout -> ERR count=%0d", tag, exp_count);
                return;
            end
            bus.imem_ack = (k == idel);
            bus.dmem_ack = 1'($urandom_range(0, 1));
            step(mk(1, 0, 0, k == idel, 0, 0, 2'b00, 1, 0, 0), {tag, "_fetch"});
            if (k == idel) break;
        end
        bus.imem_ack = 1'($urandom_range(0, 1));
        bus.dmem_ack = 1'($urandom_range(0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0), {tag, "_decode"});
        if (hlt) begin
            step(v_halt(), {tag, "_halt"});
            check_count({tag, "_cnt"});
            $display("instr %s: halt count=%0d", tag, exp_count);
            return;
        end
        ret = !mr && !mw && !rw;
        bus.imem_ack = 1'($urandom_range(0, 1));
        bus.dmem_ack = 1'($urandom_range(0, 1));
        step(mk(0, 0, 0, 0, 0, ret, ret ? psel : 2'b00, 1, 0, 0), {tag, "_exec"});
        if (ret) count_retire();
        if (mr || mw) begin
            for (int j = 0; j <= TMO; j++) begin
                if (j == TMO) begin
                    bus.dmem_ack = 1'b0;
                    step(v_err(), {tag, "_merr"});
                    check_count({tag, "_cnt"});
                    return;
                end
                last = (j == ddel);
                bus.dmem_ack = last;
                bus.imem_ack = 1'($urandom_range(0, 1));
                ret = last && !mr;
                step(mk(0, 1, mw, 0, 0, ret, ret ? psel : 2'b00, 1, 0, 0), {tag, "_mem"});
                if (ret) count_retire();
                if (last) break;
            end
        end
        if (mr || (!mw && rw)) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.dmem_ack = 1'($urandom_range(0, 1));
            step(mk(0, 0, 0, 0, 1, 1, psel, 1, 0, 0), {tag, "_wb"});
            count_retire();
        end
        check_count({tag, "_cnt"});
        $display("instr %s: rw=%0b mr=%0b mw=%0b br=%0b bt=%0b j=%0b idel=%0d ddel=%0d count=%0d",
                 tag, rw, mr, mw, br, bt, jmp, idel, ddel, exp_count);
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (obs === V_IDLE) else begin
            errors++;
            $error("FAIL %s_outs observed=%b expected=%b", tag, obs, V_IDLE);
        end
        checks++;
        assert (bus.instr_count === 16'd0) else begin
            errors++;
            $error("FAIL %s_cnt observed=%h expected=%h", tag, bus.instr_count, 16'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_count = 0;
        $display("reset %s", tag);
    endtask

    task automatic start_run(input string tag);
        bus.start = 1'b1;
        step(V_IDLE, {tag, "_idle"});
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0;
        bus.branch = 0; bus.jump = 0; bus.halt = 0; bus.branch_taken = 0;
        bus.imem_ack = 0; bus.dmem_ack = 0;
        @(posedge clk);
        #1;
        do_reset("por");
        step(V_IDLE, "idle_hold");

        // Directed program
        start_run("prog");
        run_instr("add",  1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("ld",   1, 1, 0, 0, 0, 0, 0, 0, 3);
        run_instr("beq",  0, 0, 0, 1, 1, 0, 0, 1, 0);
        run_instr("bne",  0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr("jal",  1, 0, 0, 0, 0, 1, 0, 2, 0);
        run_instr("st",   0, 0, 1, 0, 0, 0, 0, 0, 1);
        run_instr("ack15", 1, 0, 0, 0, 0, 0, 0, TMO - 1, 0);
        run_instr("mack15", 0, 1, 0, 0, 0, 0, 0, 0, TMO - 1);

        // Random instructions
        for (int n = 0; n < 40; n++) begin
            run_instr($sformatf("rnd%0d", n),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        // HALT: terminal, start ignored, left only by reset
        run_instr("hlt", 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int n = 0; n < 3; n++) begin
            bus.start = 1'b1;
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.dmem_ack = 1'($urandom_range(0, 1));
            step(v_halt(), "halt_hold");
        end
        bus.start = 1'b0;
        do_reset("halt_rst");
        step(V_IDLE, "post_halt_idle");

        // Fetch timeout -> sticky ERR
        start_run("to");
        run_instr("add2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("tmo",  1, 0, 0, 0, 0, 0, 0, TMO, 0);
        for (int n = 0; n < 3; n++) begin
            bus.start = 1'b1;
            bus.imem_ack = 1'b1;
            step(v_err(), "err_hold");
        end
        bus.start = 1'b0;
        bus.imem_ack = 1'b0;
        do_reset("err_rst");
        step(V_IDLE, "post_err_idle");

        // Reset in the middle of a data access: dropped without retire
        start_run("mid");
        run_instr("add3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.reg_write = 1; bus.mem_read = 1; bus.mem_write = 0;
        bus.branch = 0; bus.jump = 0; bus.halt = 0;
        bus.imem_ack = 1'b1;
        step(mk(1, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0), "mid_fetch");
        bus.imem_ack = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0), "mid_decode");
        step(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0), "mid_exec");
        step(mk(0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0), "mid_mem");
        do_reset("mid_mem_rst");
        bus.dmem_ack = 1'b1;
        step(V_IDLE, "mid_idle");
        bus.dmem_ack = 1'b0;
        check_count("mid_cnt");

        // Saturation of the retire counter
        @(negedge clk);
        force dut.instr_count_reg = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.instr_count_reg;
        exp_count = 65534;
        check_count("sat_preload");
        start_run("sat");
        run_instr("sat_add", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("sat_beq", 0, 0, 0, 1, 1, 0, 0, 1, 0);
        run_instr("sat_st",  0, 0, 1, 0, 0, 0, 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
